// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
package cpu_ctrl_pkg;

    // FSM phases; encodings are visible on the State debug port.
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    // Opcodes taken from IR[15:12].
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Datapath control bundle driven by the decoder.
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       illegal;
        logic       halted;
    } ctrl_t;

    // True for every opcode the datapath implements (HALT included).
    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW)    || (op == OP_BEQ)  || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational control decode: (state, opcode, Zero, MemReady) -> datapath controls.
import cpu_ctrl_pkg::*;

module mc_decode (
    input  state_t     state_i,
    input  logic [3:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Every control defaults low; each phase raises only what it needs.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b0;
                // IR and PC load only in the cycle memory returns the word.
                if (mem_ready_i) begin
                    ctrl_o.ir_write = 1'b1;
                    ctrl_o.pc_write = 1'b1;
                    ctrl_o.pc_src   = 1'b0;
                end
            end
            DECODE: begin
                ctrl_o.illegal = !op_legal(opcode_i);
            end
            EXECUTE: begin
                case (opcode_i)
                    OP_RTYPE: begin
                        ctrl_o.alu_src = 1'b0;
                        ctrl_o.alu_op  = ALU_FUNCT;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ctrl_o.alu_src = 1'b1;
                        ctrl_o.alu_op  = ALU_ADD;
                    end
                    OP_BEQ: begin
                        ctrl_o.alu_src  = 1'b0;
                        ctrl_o.alu_op   = ALU_SUB;
                        ctrl_o.branch   = 1'b1;
                        ctrl_o.pc_src   = 1'b1;
                        ctrl_o.pc_write = zero_i;
                    end
                    default: ;
                endcase
            end
            MEMORY: begin
                // Request fields are independent of MemReady so they hold through waits.
                if (opcode_i == OP_LW || opcode_i == OP_SW) begin
                    ctrl_o.mem_req   = 1'b1;
                    ctrl_o.iord      = 1'b1;
                    ctrl_o.mem_read  = (opcode_i == OP_LW);
                    ctrl_o.mem_write = (opcode_i == OP_SW);
                end
            end
            WRITEBACK: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = (opcode_i == OP_RTYPE);
                ctrl_o.mem_to_reg = (opcode_i == OP_LW);
            end
            HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Five-phase multi-cycle sequencer: state register, next-state logic, retire counter.
import cpu_ctrl_pkg::*;

module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic             Illegal,
    output logic             Halted,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    ctrl_t            ctrl, ctrl_out;

    mc_decode u_dec (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (Zero),
        .mem_ready_i (MemReady),
        .ctrl_o      (ctrl)
    );

    // Next phase; retire marks an instruction completing on its way back to FETCH.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH: begin
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                if (!op_legal(opcode))     state_d = FETCH;
                else if (opcode == OP_HALT) state_d = HALT;
                else                        state_d = EXECUTE;
            end
            EXECUTE: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_d = WRITEBACK;
                    OP_LW, OP_SW:      state_d = MEMORY;
                    OP_BEQ: begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                    default:           state_d = FETCH;
                endcase
            end
            MEMORY: begin
                if (MemReady) begin
                    if (opcode == OP_LW) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FETCH;
                        retire  = (opcode == OP_SW);
                    end
                end
            end
            WRITEBACK: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        cnt_d = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    // State and counter registers; Reset wins over a simultaneous retire.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces every output quiet, abandoning any in-flight memory request at once.
    always_comb begin
        ctrl_out   = Reset ? '0 : ctrl;
        State      = Reset ? 3'(FETCH) : 3'(state_q);
        InstrCount = Reset ? '0 : cnt_q;
    end

    assign MemReq   = ctrl_out.mem_req;
    assign MemRead  = ctrl_out.mem_read;
    assign MemWrite = ctrl_out.mem_write;
    assign IorD     = ctrl_out.iord;
    assign IRWrite  = ctrl_out.ir_write;
    assign PCWrite  = ctrl_out.pc_write;
    assign PCSrc    = ctrl_out.pc_src;
    assign RegDst   = ctrl_out.reg_dst;
    assign ALUSrc   = ctrl_out.alu_src;
    assign MemToReg = ctrl_out.mem_to_reg;
    assign RegWrite = ctrl_out.reg_write;
    assign Branch   = ctrl_out.branch;
    assign ALUOp    = ctrl_out.alu_op;
    assign Illegal  = ctrl_out.illegal;
    assign Halted   = ctrl_out.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: vector table plus hand sequences.
module tb_multicycle_control;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] opcode;
    logic       Zero, MemReady;
    logic       MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc;
    logic       RegDst, ALUSrc, MemToReg, RegWrite, Branch, Illegal, Halted;
    logic [1:0] ALUOp;
    logic [2:0] State;
    logic [3:0] InstrCount;

    multicycle_control #(.CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
        .MemReq(MemReq), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite), .Branch(Branch),
        .ALUOp(ALUOp), .Illegal(Illegal), .Halted(Halted), .State(State),
        .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    // Control bits, MSB first:
    // MemReq MemRead MemWrite IorD | IRWrite PCWrite PCSrc RegDst |
    // ALUSrc MemToReg RegWrite Branch | ALUOp[1:0] Illegal Halted
    logic [15:0] act_ctl;
    assign act_ctl = {MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegDst,
                      ALUSrc, MemToReg, RegWrite, Branch, ALUOp, Illegal, Halted};

    localparam logic [15:0] C_NONE  = 16'h0000;
    localparam logic [15:0] C_FWAIT = 16'hC000;
    localparam logic [15:0] C_FRDY  = 16'hCC00;
    localparam logic [15:0] C_DILL  = 16'h0002;
    localparam logic [15:0] C_ER    = 16'h0008;
    localparam logic [15:0] C_EIMM  = 16'h0080;
    localparam logic [15:0] C_EBQ1  = 16'h0614;
    localparam logic [15:0] C_EBQ0  = 16'h0214;
    localparam logic [15:0] C_MLW   = 16'hD000;
    localparam logic [15:0] C_MSW   = 16'hB000;
    localparam logic [15:0] C_WR    = 16'h0120;
    localparam logic [15:0] C_WADDI = 16'h0020;
    localparam logic [15:0] C_WLW   = 16'h0060;
    localparam logic [15:0] C_HALT  = 16'h0001;

    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW_ = 3'd4, SH = 3'd5;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [15:0] ctl;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] op, input logic z,
                                input logic rdy, input logic [2:0] st,
                                input logic [15:0] ctl, input logic [3:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
        return v;
    endfunction

    // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string nm, input logic rst, input logic [3:0] op, input logic z,
                       input logic rdy, input logic [2:0] st, input logic [15:0] ctl,
                       input logic [3:0] cnt);
        Reset = rst; opcode = op; Zero = z; MemReady = rdy;
        @(negedge Clock);
        total++;
        if (State !== st || act_ctl !== ctl || InstrCount !== cnt) begin
            bad++;
            $display("FAIL %s: got state=%0d ctl=%h cnt=%0d, want state=%0d ctl=%h cnt=%0d",
                     nm, State, act_ctl, InstrCount, st, ctl, cnt);
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; opcode = 4'h0; Zero = 1'b0; MemReady = 1'b0;

        // Reset, R-type, ADDI
        tbl.push_back(mk(1, 4'h0, 0, 1, SF, C_NONE, 0));
        tbl.push_back(mk(1, 4'h0, 0, 1, SF, C_NONE, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, SF, C_FRDY, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, SD, C_NONE, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, SE, C_ER,   0));
        tbl.push_back(mk(0, 4'h0, 0, 1, SW_, C_WR,  0));
        tbl.push_back(mk(0, 4'h1, 0, 1, SF, C_FRDY, 1));
        tbl.push_back(mk(0, 4'h1, 0, 1, SD, C_NONE, 1));
        tbl.push_back(mk(0, 4'h1, 0, 1, SE, C_EIMM, 1));
        tbl.push_back(mk(0, 4'h1, 0, 1, SW_, C_WADDI, 1));
        // LW: 3 fetch waits, 2 memory waits, 10 cycles
        tbl.push_back(mk(0, 4'h2, 0, 0, SF, C_FWAIT, 2));
        tbl.push_back(mk(0, 4'h2, 0, 0, SF, C_FWAIT, 2));
        tbl.push_back(mk(0, 4'h2, 0, 0, SF, C_FWAIT, 2));
        tbl.push_back(mk(0, 4'h2, 0, 1, SF, C_FRDY,  2));
        tbl.push_back(mk(0, 4'h2, 0, 1, SD, C_NONE,  2));
        tbl.push_back(mk(0, 4'h2, 0, 1, SE, C_EIMM,  2));
        tbl.push_back(mk(0, 4'h2, 0, 0, SM, C_MLW,   2));
        tbl.push_back(mk(0, 4'h2, 0, 0, SM, C_MLW,   2));
        tbl.push_back(mk(0, 4'h2, 0, 1, SM, C_MLW,   2));
        tbl.push_back(mk(0, 4'h2, 0, 1, SW_, C_WLW,  2));
        // BEQ taken, then not taken (Zero high outside EXECUTE is ignored)
        tbl.push_back(mk(0, 4'h4, 0, 1, SF, C_FRDY, 3));
        tbl.push_back(mk(0, 4'h4, 0, 1, SD, C_NONE, 3));
        tbl.push_back(mk(0, 4'h4, 1, 1, SE, C_EBQ1, 3));
        tbl.push_back(mk(0, 4'h4, 1, 1, SF, C_FRDY, 4));
        tbl.push_back(mk(0, 4'h4, 1, 0, SD, C_NONE, 4));
        tbl.push_back(mk(0, 4'h4, 0, 1, SE, C_EBQ0, 4));
        // SW, no waits
        tbl.push_back(mk(0, 4'h3, 0, 1, SF, C_FRDY, 5));
        tbl.push_back(mk(0, 4'h3, 0, 1, SD, C_NONE, 5));
        tbl.push_back(mk(0, 4'h3, 0, 1, SE, C_EIMM, 5));
        tbl.push_back(mk(0, 4'h3, 0, 1, SM, C_MSW,  5));
        // Illegal opcode, then an R-type to prove the count skipped it
        tbl.push_back(mk(0, 4'hA, 0, 1, SF, C_FRDY, 6));
        tbl.push_back(mk(0, 4'hA, 0, 1, SD, C_DILL, 6));
        tbl.push_back(mk(0, 4'h0, 0, 1, SF, C_FRDY, 6));
        tbl.push_back(mk(0, 4'h0, 0, 0, SD, C_NONE, 6));
        tbl.push_back(mk(0, 4'h0, 0, 1, SE, C_ER,   6));
        // Retire coincident with Reset: Reset wins
        tbl.push_back(mk(1, 4'h0, 0, 1, SF, C_NONE, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, SF, C_FWAIT, 0));

        foreach (tbl[i])
            cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].rdy,
                tbl[i].st, tbl[i].ctl, tbl[i].cnt);

        // Reset mid-access: SW stalled in MEMORY, request dropped under Reset
        cyc("sw_f",    0, 4'h3, 0, 1, SF, C_FRDY, 0);
        cyc("sw_d",    0, 4'h3, 0, 1, SD, C_NONE, 0);
        cyc("sw_e",    0, 4'h3, 0, 1, SE, C_EIMM, 0);
        cyc("sw_mw0",  0, 4'h3, 0, 0, SM, C_MSW,  0);
        cyc("sw_mw1",  0, 4'h3, 0, 0, SM, C_MSW,  0);
        cyc("sw_rst",  1, 4'h3, 0, 0, SF, C_NONE, 0);
        cyc("sw_post", 0, 4'h3, 0, 0, SF, C_FWAIT, 0);

        // Counter wrap: 16 BEQs at 3 cycles each bring a 4-bit count back to 0
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ec;
            ec = 4'(i);
            cyc($sformatf("wrap%0d_f", i), 0, 4'h4, 0, 1, SF, C_FRDY, ec);
            cyc($sformatf("wrap%0d_d", i), 0, 4'h4, 0, 1, SD, C_NONE, ec);
            cyc($sformatf("wrap%0d_e", i), 0, 4'h4, 0, 1, SE, C_EBQ0, ec);
        end
        cyc("wrap_end", 0, 4'h0, 0, 0, SF, C_FWAIT, 4'd0);

        // HALT holds for 20 cycles regardless of MemReady, then Reset recovers
        cyc("halt_f", 0, 4'hF, 0, 1, SF, C_FRDY, 0);
        cyc("halt_d", 0, 4'hF, 0, 1, SD, C_NONE, 0);
        for (int i = 0; i < 20; i++)
            cyc($sformatf("halt%0d", i), 0, 4'hF, i[0], i[1], SH, C_HALT, 0);
        cyc("halt_rst",  1, 4'hF, 0, 1, SF, C_NONE, 0);
        cyc("halt_post", 0, 4'h0, 0, 1, SF, C_FRDY, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
